// File: rtl/sub_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sub_div_ctrl_if
// Description : Request/result bundle between a divide requester and
//               sub_div_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface sub_div_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/sub_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sub_div_ctrl
// Description : Restoring divider by repeated subtraction on one shared
//               ripple-carry subtractor, one subtraction per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_div_ctrl #(
  parameter int WIDTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  sub_div_ctrl_if.slave bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_dbz;

  logic [WIDTH-1:0] w_nb;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH:0]   w_carry;
  logic             w_cout;
  logic             w_accept;
  logic             w_zero;
  logic             w_busy;
  logic             w_done;

  // Shared subtractor: r_rem + ~r_dvs + 1; carry-out high means r_rem >= r_dvs
  assign w_nb       = ~r_dvs;
  assign w_carry[0] = 1'b1;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign w_diff[i]      = r_rem[i] ^ w_nb[i] ^ w_carry[i];
      assign w_carry[i+1]   = (r_rem[i] & w_nb[i]) | (w_carry[i] & (r_rem[i] ^ w_nb[i]));
    end
  endgenerate

  assign w_cout   = w_carry[WIDTH];
  assign w_accept = bus.start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_zero   = (bus.divisor == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle,
      c_st_done: begin
        if (bus.start) begin
          w_next = w_zero ? c_st_done : c_st_run;
        end else begin
          w_next = c_st_idle;
        end
      end
      c_st_run:  w_next = w_cout ? c_st_run : c_st_done;
      default:   w_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      c_st_run:  w_busy = 1'b1;
      c_st_done: w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Published results move only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_dvs  <= '0;
      r_q    <= '0;
      r_quot <= '0;
      r_remd <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_rem <= bus.dividend;
      r_dvs <= bus.divisor;
      r_q   <= '0;
      if (w_zero) begin
        r_quot <= '1;
        r_remd <= bus.dividend;
        r_dbz  <= 1'b1;
      end
    end else if (r_state == c_st_run) begin
      if (w_cout) begin
        r_rem <= w_diff;
        r_q   <= r_q + WIDTH'(1);
      end else begin
        r_quot <= r_q;
        r_remd <= r_rem;
        r_dbz  <= 1'b0;
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_sub_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_div_ctrl
// Description : Directed and full-operand-sweep checks for sub_div_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_div_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sub_div_ctrl_if #(.WIDTH(4)) bus ();

  sub_div_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting edge
  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
  endtask

  // lat = edges after the accepting edge until done is seen; returns at a negedge with done high
  task automatic wait_done(input int inj, output int lat, output int bcnt, output logic [3:0] q0);
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    bus.start = 1'b0;
    q0 = bus.quotient;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      bus.start = (lat == inj);
      if (lat == inj) begin
        bus.dividend = 4'd5;
        bus.divisor  = 4'd5;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk("done_seen", bus.done, 1);
  endtask

  initial begin
    int         lat;
    int         bcnt;
    int         dcnt;
    logic [3:0] q0;

    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor  = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quot", bus.quotient, 0);
    chk("rst_rem",  bus.remainder, 0);
    chk("rst_dbz",  bus.div_by_zero, 0);

    launch(4'd13, 4'd4);
    wait_done(-1, lat, bcnt, q0);
    chk("13/4_lat",  lat, 4);
    chk("13/4_busy", bcnt, 4);
    chk("13/4_q",    bus.quotient, 3);
    chk("13/4_r",    bus.remainder, 1);
    chk("13/4_dbz",  bus.div_by_zero, 0);
    chk("13/4_busy_at_done", bus.busy, 0);

    launch(4'd15, 4'd1);
    wait_done(-1, lat, bcnt, q0);
    chk("15/1_lat", lat, 16);
    chk("15/1_q",   bus.quotient, 15);
    chk("15/1_r",   bus.remainder, 0);

    launch(4'd3, 4'd7);
    wait_done(-1, lat, bcnt, q0);
    chk("3/7_lat", lat, 1);
    chk("3/7_q",   bus.quotient, 0);
    chk("3/7_r",   bus.remainder, 3);

    launch(4'd9, 4'd0);
    wait_done(-1, lat, bcnt, q0);
    chk("9/0_lat",  lat, 0);
    chk("9/0_busy", bcnt, 0);
    chk("9/0_dbz",  bus.div_by_zero, 1);
    chk("9/0_q",    bus.quotient, 15);
    chk("9/0_r",    bus.remainder, 9);
    chk("9/0_busy_at_done", bus.busy, 0);

    // Start pulse with 5/5 during the second RUN cycle must be ignored
    launch(4'd14, 4'd3);
    wait_done(1, lat, bcnt, q0);
    chk("14/3_lat", lat, 5);
    chk("14/3_q",   bus.quotient, 4);
    chk("14/3_r",   bus.remainder, 2);
    chk("14/3_dbz", bus.div_by_zero, 0);

    // Start during the DONE cycle: accepted with no IDLE gap
    launch(4'd5, 4'd5);
    wait_done(-1, lat, bcnt, q0);
    chk("b2b_hold_q", q0, 4);
    chk("b2b_lat",    lat, 2);
    chk("b2b_busy",   bcnt, 2);
    chk("b2b_q",      bus.quotient, 1);
    chk("b2b_r",      bus.remainder, 0);

    // Abort a 12/2 divide with rst in its third RUN cycle
    launch(4'd12, 4'd2);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_busy", bus.busy, 1);
    chk("abort_pre_hold", bus.quotient, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_q",    bus.quotient, 0);
    chk("abort_r",    bus.remainder, 0);
    rst  = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(4'(a), 4'(b));
        wait_done(-1, lat, bcnt, q0);
        if (b == 0) begin
          chk("sweep_lat", lat, 0);
          chk("sweep_q",   bus.quotient, 15);
          chk("sweep_r",   bus.remainder, a);
          chk("sweep_dbz", bus.div_by_zero, 1);
        end else begin
          chk("sweep_lat", lat, a / b + 1);
          chk("sweep_q",   bus.quotient, a / b);
          chk("sweep_r",   bus.remainder, a % b);
          chk("sweep_dbz", bus.div_by_zero, 0);
          chk("sweep_inv", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), a);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
